// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter and the 4:1 mux side.
// The lock signal exists only when MUX_ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] select;
    logic [3:0] grant;
    logic       out_valid;
    logic [3:0] ready;
`ifdef MUX_ARB_LOCK_EN
    logic       lock;

    modport master (input req, out_ready, lock, output select, grant, out_valid, ready);
    modport slave  (output req, out_ready, lock, input select, grant, out_valid, ready);
`else
    modport master (input req, out_ready, output select, grant, out_valid, ready);
    modport slave  (output req, out_ready, input select, grant, out_valid, ready);
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin select generator for a 4:1 4-bit channel mux with a per-grant hold limit.
// Optional feature: define MUX_ARB_LOCK_EN to add a lock input that pins the current grant.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.master  bus
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        select_q, select_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        grant_q, grant_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic              valid;
    logic              xfer;
    logic              lock_on;
    logic              take_new;
    logic [1:0]        new_idx;
    logic [2:0]        pick_all;
    logic [2:0]        pick_other;

    // Returns {found, index} of the first set bit of cand, scanning start, start+1, ... mod 4.
    function automatic logic [2:0] pick(input logic [3:0] cand, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef MUX_ARB_LOCK_EN
    assign lock_on = bus.lock;
`else
    assign lock_on = 1'b0;
`endif

    // Handshake outputs are suppressed during reset so a reset never pops a word.
    assign valid         = rst_n && (state_q == GRANT) && bus.req[select_q];
    assign xfer          = valid && bus.out_ready;
    assign bus.out_valid = valid;
    assign bus.ready     = xfer ? grant_q : 4'b0000;
    assign bus.select    = select_q;
    assign bus.grant     = grant_q;

    assign pick_all   = pick(bus.req, ptr_q);
    assign pick_other = pick(bus.req & ~grant_q, ptr_q);

    always_comb begin
        state_d    = state_q;
        select_d   = select_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        take_new   = 1'b0;
        new_idx    = pick_other[1:0];

        case (state_q)
            IDLE: begin
                if (pick_all[2]) begin
                    take_new = 1'b1;
                    new_idx  = pick_all[1:0];
                end
            end
            GRANT: begin
                if (bus.req[select_q]) begin
                    if (xfer) begin
                        // Under lock the counter saturates at the limit so an unlock rotates on the next word.
                        if (lock_on) begin
                            if (int'(hold_cnt_q) < MAX_HOLD) begin
                                hold_cnt_d = hold_cnt_q + 1'b1;
                            end
                        end else if (int'(hold_cnt_q) + 1 < MAX_HOLD) begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end else if (pick_other[2]) begin
                            take_new = 1'b1;
                        end else begin
                            hold_cnt_d = '0;
                        end
                    end
                end else if (pick_other[2]) begin
                    take_new = 1'b1;
                end else begin
                    state_d    = IDLE;
                    grant_d    = 4'b0000;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every fresh grant, including rotations, restarts the count and advances the pointer.
        if (take_new) begin
            state_d    = GRANT;
            select_d   = new_idx;
            grant_d    = 4'b0001 << new_idx;
            ptr_d      = new_idx + 2'd1;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            select_q   <= 2'd0;
            grant_q    <= 4'b0000;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: three instances (MAX_HOLD 1, 4, 2) share one stimulus stream
// and are compared against an integer-level round-robin model.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic       lock;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_if if_a ();
    mux_rr_arbiter_if if_b ();
    mux_rr_arbiter_if if_c ();

    assign if_a.req = req;
    assign if_b.req = req;
    assign if_c.req = req;
    assign if_a.out_ready = out_ready;
    assign if_b.out_ready = out_ready;
    assign if_c.out_ready = out_ready;
`ifdef MUX_ARB_LOCK_EN
    assign if_a.lock = lock;
    assign if_b.lock = lock;
    assign if_c.lock = lock;
`endif

    mux_rr_arbiter #(.MAX_HOLD(1)) u_h1 (.clk(clk), .rst_n(rst_n), .bus(if_a.master));
    mux_rr_arbiter #(.MAX_HOLD(4)) u_h4 (.clk(clk), .rst_n(rst_n), .bus(if_b.master));
    mux_rr_arbiter #(.MAX_HOLD(2)) u_h2 (.clk(clk), .rst_n(rst_n), .bus(if_c.master));

    logic [1:0] d_sel   [3];
    logic [3:0] d_grant [3];
    logic       d_valid [3];
    logic [3:0] d_ready [3];

    assign d_sel[0]   = if_a.select;
    assign d_sel[1]   = if_b.select;
    assign d_sel[2]   = if_c.select;
    assign d_grant[0] = if_a.grant;
    assign d_grant[1] = if_b.grant;
    assign d_grant[2] = if_c.grant;
    assign d_valid[0] = if_a.out_valid;
    assign d_valid[1] = if_b.out_valid;
    assign d_valid[2] = if_c.out_valid;
    assign d_ready[0] = if_a.ready;
    assign d_ready[1] = if_b.ready;
    assign d_ready[2] = if_c.ready;

    // Reference model: owner channel, words taken in this grant, next round-robin start.
    int m_act [3];
    int m_sel [3];
    int m_cnt [3];
    int m_ptr [3];

    function automatic int hold_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int first_req(input logic [3:0] mask, input int start);
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (start + i) % 4;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic exp_valid(input int k);
        return (rst_n === 1'b1) && (m_act[k] != 0) && (req[m_sel[k]] === 1'b1);
    endfunction

    function automatic logic [3:0] exp_ready(input int k);
        return (exp_valid(k) && out_ready) ? 4'(1 << m_sel[k]) : 4'b0000;
    endfunction

    function automatic logic [3:0] exp_grant(input int k);
        return (m_act[k] != 0) ? 4'(1 << m_sel[k]) : 4'b0000;
    endfunction

    function automatic logic lock_active();
`ifdef MUX_ARB_LOCK_EN
        return lock === 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void grant_to(input int k, input int n);
        m_act[k] = 1;
        m_sel[k] = n;
        m_cnt[k] = 0;
        m_ptr[k] = (n + 1) % 4;
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 3; k++) begin
            int h;
            int nxt;
            bit xf;
            h  = hold_of(k);
            xf = exp_valid(k) && out_ready;
            if (rst_n !== 1'b1) begin
                m_act[k] = 0;
                m_sel[k] = 0;
                m_cnt[k] = 0;
                m_ptr[k] = 0;
            end else if (m_act[k] == 0) begin
                nxt = first_req(req, m_ptr[k]);
                if (nxt >= 0) grant_to(k, nxt);
            end else if (req[m_sel[k]]) begin
                if (xf) begin
                    if (lock_active()) begin
                        m_cnt[k] = (m_cnt[k] + 1 > h) ? h : m_cnt[k] + 1;
                    end else if (m_cnt[k] + 1 < h) begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end else begin
                        nxt = first_req(req & ~4'(1 << m_sel[k]), m_ptr[k]);
                        if (nxt >= 0) grant_to(k, nxt);
                        else m_cnt[k] = 0;
                    end
                end
            end else begin
                nxt = first_req(req, m_ptr[k]);
                if (nxt >= 0) begin
                    grant_to(k, nxt);
                end else begin
                    m_act[k] = 0;
                    m_cnt[k] = 0;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        lock      = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        lock      = 1'b0;
        repeat (2) tick();
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (d_grant[k] !== 4'b0000) begin bad++; $display("[TB] FAIL reset_grant dut=%0d got=%b exp=0000", k, d_grant[k]); end
            total++;
            if (d_sel[k] !== 2'd0) begin bad++; $display("[TB] FAIL reset_select dut=%0d got=%0d exp=0", k, d_sel[k]); end
            total++;
            if (d_valid[k] !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid dut=%0d got=%b exp=0", k, d_valid[k]); end
            total++;
            if (d_ready[k] !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready dut=%0d got=%b exp=0000", k, d_ready[k]); end
        end
        rst_n = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (d_ready[k] !== 4'b0000) begin bad++; $display("[TB] FAIL midreset_ready dut=%0d got=%b exp=0000", k, d_ready[k]); end
            total++;
            if (d_valid[k] !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid dut=%0d got=%b exp=0", k, d_valid[k]); end
        end
        tick();
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (d_grant[k] !== 4'b0000) begin bad++; $display("[TB] FAIL midreset_grant dut=%0d got=%b exp=0000", k, d_grant[k]); end
            total++;
            if (d_sel[k] !== 2'd0) begin bad++; $display("[TB] FAIL midreset_select dut=%0d got=%0d exp=0", k, d_sel[k]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fair_rotation();
        do_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            #1;
            total++;
            if (d_sel[0] !== 2'(i % 4)) begin bad++; $display("[TB] FAIL rot_select cyc=%0d got=%0d exp=%0d", i, d_sel[0], i % 4); end
            total++;
            if (d_ready[0] !== 4'(1 << (i % 4))) begin bad++; $display("[TB] FAIL rot_ready cyc=%0d got=%b exp=%b", i, d_ready[0], 4'(1 << (i % 4))); end
            tick();
        end
    endtask

    task automatic test_hold_limit();
        int e;
        do_reset();
        req       = 4'b0101;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            e = ((i / 4) % 2 == 0) ? 0 : 2;
            #1;
            total++;
            if (d_sel[1] !== 2'(e)) begin bad++; $display("[TB] FAIL hold_select cyc=%0d got=%0d exp=%0d", i, d_sel[1], e); end
            total++;
            if (d_ready[1] !== 4'(1 << e)) begin bad++; $display("[TB] FAIL hold_ready cyc=%0d got=%b exp=%b", i, d_ready[1], 4'(1 << e)); end
            total++;
            if (int'(u_h4.hold_cnt_q) != i % 4) begin bad++; $display("[TB] FAIL hold_cnt cyc=%0d got=%0d exp=%0d", i, u_h4.hold_cnt_q, i % 4); end
            tick();
        end
        req = 4'b0100;
        #1;
        total++;
        if (d_valid[1] !== 1'b0) begin bad++; $display("[TB] FAIL single_release_valid got=%b exp=0", d_valid[1]); end
        tick();
        for (int i = 1; i < 13; i++) begin
            #1;
            total++;
            if (d_sel[1] !== 2'd2) begin bad++; $display("[TB] FAIL single_select cyc=%0d got=%0d exp=2", i, d_sel[1]); end
            total++;
            if (d_ready[1] !== 4'b0100) begin bad++; $display("[TB] FAIL single_ready cyc=%0d got=%b exp=0100", i, d_ready[1]); end
            total++;
            if (int'(u_h4.hold_cnt_q) != (i - 1) % 4) begin bad++; $display("[TB] FAIL single_cnt cyc=%0d got=%0d exp=%0d", i, u_h4.hold_cnt_q, (i - 1) % 4); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req       = 4'b0010;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (d_sel[1] !== 2'd1) begin bad++; $display("[TB] FAIL bp_select cyc=%0d got=%0d exp=1", i, d_sel[1]); end
            total++;
            if (d_valid[1] !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid cyc=%0d got=%b exp=1", i, d_valid[1]); end
            total++;
            if (d_ready[1] !== 4'b0000) begin bad++; $display("[TB] FAIL bp_ready cyc=%0d got=%b exp=0000", i, d_ready[1]); end
            total++;
            if (int'(u_h4.hold_cnt_q) != 1) begin bad++; $display("[TB] FAIL bp_cnt cyc=%0d got=%0d exp=1", i, u_h4.hold_cnt_q); end
            tick();
        end
    endtask

    task automatic test_release();
        do_reset();
        req       = 4'b1010;
        out_ready = 1'b0;
        tick();
        #1;
        total++;
        if (d_sel[1] !== 2'd1) begin bad++; $display("[TB] FAIL rel_first_select got=%0d exp=1", d_sel[1]); end
        req = 4'b1000;
        tick();
        #1;
        total++;
        if (d_sel[1] !== 2'd3) begin bad++; $display("[TB] FAIL rel_next_select got=%0d exp=3", d_sel[1]); end
        total++;
        if (d_grant[1] !== 4'b1000) begin bad++; $display("[TB] FAIL rel_next_grant got=%b exp=1000", d_grant[1]); end
        total++;
        if (d_valid[1] !== 1'b1) begin bad++; $display("[TB] FAIL rel_next_valid got=%b exp=1", d_valid[1]); end

        do_reset();
        req = 4'b0010;
        tick();
        #1;
        total++;
        if (d_grant[1] !== 4'b0010) begin bad++; $display("[TB] FAIL idle_pre_grant got=%b exp=0010", d_grant[1]); end
        req = 4'b0000;
        #1;
        total++;
        if (d_valid[1] !== 1'b0) begin bad++; $display("[TB] FAIL idle_drop_valid got=%b exp=0", d_valid[1]); end
        tick();
        #1;
        total++;
        if (d_grant[1] !== 4'b0000) begin bad++; $display("[TB] FAIL idle_grant got=%b exp=0000", d_grant[1]); end
        total++;
        if (d_valid[1] !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid got=%b exp=0", d_valid[1]); end
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        lock      = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (d_sel[2] !== 2'd0) begin bad++; $display("[TB] FAIL lock_select cyc=%0d got=%0d exp=0", i, d_sel[2]); end
            total++;
            if (d_ready[2] !== 4'b0001) begin bad++; $display("[TB] FAIL lock_ready cyc=%0d got=%b exp=0001", i, d_ready[2]); end
            tick();
        end
        lock = 1'b0;
        #1;
        total++;
        if (d_ready[2] !== 4'b0001) begin bad++; $display("[TB] FAIL unlock_last_ready got=%b exp=0001", d_ready[2]); end
        tick();
        #1;
        total++;
        if (d_sel[2] !== 2'd1) begin bad++; $display("[TB] FAIL unlock_rotate got=%0d exp=1", d_sel[2]); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 60) != 0);
`ifdef MUX_ARB_LOCK_EN
            lock = ($urandom_range(0, 4) == 0);
`else
            lock = 1'b0;
`endif
            #1;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (d_sel[k] !== 2'(m_sel[k])) begin bad++; $display("[TB] FAIL rnd_select cyc=%0d dut=%0d got=%0d exp=%0d", i, k, d_sel[k], m_sel[k]); end
                total++;
                if (d_grant[k] !== exp_grant(k)) begin bad++; $display("[TB] FAIL rnd_grant cyc=%0d dut=%0d got=%b exp=%b", i, k, d_grant[k], exp_grant(k)); end
                total++;
                if (d_valid[k] !== exp_valid(k)) begin bad++; $display("[TB] FAIL rnd_valid cyc=%0d dut=%0d got=%b exp=%b", i, k, d_valid[k], exp_valid(k)); end
                total++;
                if (d_ready[k] !== exp_ready(k)) begin bad++; $display("[TB] FAIL rnd_ready cyc=%0d dut=%0d got=%b exp=%b", i, k, d_ready[k], exp_ready(k)); end
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        lock      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_act[k] = 0;
            m_sel[k] = 0;
            m_cnt[k] = 0;
            m_ptr[k] = 0;
        end
        @(negedge clk);
        test_reset();
        test_fair_rotation();
        test_hold_limit();
        test_backpressure();
        test_release();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
